plab5_mcore_mem_req_tracker: RTL
================================

# plab5_mcore_mem_req_tracker

Sits directly downstream of the proc2mem message translator on the memory side. It forwards translated 128-bit memory requests to main memory with zero added latency, and records each accepted request's security domain, opaque, and type in an in-order outstanding FIFO. It pairs each memory response with the oldest record, so the response path back to the translator carries a trustworthy `resp_domain`. Mismatched or unsolicited responses are flagged, never silently relabelled to a lower domain.

## Interface
Parameters:
- `o`, 8, opaque field width
- `a`, 32, address field width
- `md`, 128, memory data width; request message = `VC_MEM_REQ_MSG_NBITS(o,a,md)` (175), response message = `VC_MEM_RESP_MSG_NBITS(o,md)` (143)
- `num_entries`, 4, outstanding-request capacity; power of two, ≥2

Ports:
- `clk`  in  1  clock; everything is on the rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `req_domain`  in  1  domain of `req_msg` ({L}; 0 = low, 1 = high)
- `req_msg`  in  175  translated request from the translator
- `req_val` in 1 / `req_rdy` out 1  upstream request handshake
- `memreq_msg`  out  175  request to memory (= `req_msg`)
- `memreq_domain`  out  1  (= `req_domain`)
- `memreq_val` out 1 / `memreq_rdy` in 1  memory request handshake
- `memresp_msg`  in  143  response from memory
- `memresp_val` in 1 / `memresp_rdy` out 1  memory response handshake
- `resp_msg`  out  143  response to the translator (= `memresp_msg`)
- `resp_domain`  out  1  domain label for `resp_msg`
- `resp_val` out 1 / `resp_rdy` in 1  response handshake to the translator
- `count`  out  clog2(num_entries)+1  number of outstanding entries
- `err`  out  1  sticky protocol error

## Operation
- Entry layout: {domain, opaque, type}.
- The tracker is full when `count == num_entries` and empty when `count == 0`. Both flags come from registered `count`.
- Request path is combinational:
  - `memreq_val = req_val & ~full`
  - `req_rdy = memreq_rdy & ~full`
  - Push happens when `req_val & req_rdy`.
  - On push, write {req_domain, opaque, type} at the tail and increment the tail mod `num_entries`.
- Response path, when not empty:
  - `resp_val = memresp_val`
  - `memresp_rdy = resp_rdy`
  - Pop happens when `memresp_val & resp_rdy`. On pop, the head advances mod `num_entries`.
- `resp_domain`:
  - Equals head.domain when the response opaque and type match head.opaque and head.type.
  - Otherwise it is forced to 1 (high) and `err` is set on the handshake.
- Response while empty (unsolicited):
  - `memresp_rdy = 1`, `resp_val = 0`; the response is dropped.
  - `err` is set on the cycle `memresp_val` is high.
- Simultaneous push and pop: both occur and `count` is unchanged. When full, a push is refused even if a pop happens in the same cycle.
- `err` clears only on reset.

## Timing
- Request and response paths add 0 cycles; all `val`/`rdy`/`msg` outputs are combinational from inputs and registered state.
- `count`, pointers, and `err` update on the clock edge following the handshake.
- While `reset` = 0:
  - `req_rdy`, `memreq_val`, `resp_val` = 0; `memresp_rdy` = 0.
  - Next edge sets `count` = 0, head = tail = 0, `err` = 0.
  - `resp_domain` = 1.
- Reset mid-operation discards all outstanding entries. Memory shares the same reset, so stale responses are not expected; if one arrives it is treated as unsolicited.
- Entry storage needs no reset; valid state is defined by `count` only.

## Structure
- Shared header `plab5-mcore-mem-tracker-defs.v`:
  - entry width macro (1+o+3)
  - field-slice macros for domain/opaque/type
  - domain constants `DOMAIN_LOW`=0, `DOMAIN_HIGH`=1
- Message field slicing reuses `vc-mem-msgs.v` macros.
- One sub-module, `plab5_mcore_tracker_fifo`: a synchronous circular buffer with push/pop, `count`, and full/empty outputs. The top level holds the handshake gating and the match/err logic.

## Test plan
- Single read: push type 0, opaque 0x05, domain 1; response opaque 0x05, type 0 two cycles later → `resp_val` = 1, `resp_domain` = 1, `count` goes 1 → 0, `err` = 0.
- Fill: 4 pushes with `memreq_rdy` = 1 and no responses → `count` = 4, fifth `req_val` sees `req_rdy` = 0 and `memreq_val` = 0. Pop plus push in the same cycle while full → push refused, `count` = 3.
- In-order domains: push domains 0,1,0 with opaques 0x10,0x11,0x12; return responses in order with `resp_rdy` toggling → `resp_domain` sequence 0,1,0, no loss or duplication.
- Mismatch: head opaque 0x20 domain 0, response opaque 0x21 → `resp_domain` = 1, `err` = 1 and sticky, entry popped.
- Unsolicited/backpressure: response while `count` = 0 → `memresp_rdy` = 1, `resp_val` = 0, `err` = 1. With `resp_rdy` = 0 and an entry held → `memresp_rdy` = 0, `count` held.
- Reset: assert `reset` = 0 with 3 outstanding → next edge `count` = 0, `err` = 0, `req_rdy` = 0 during reset, `req_rdy` = `memreq_rdy` after release.

Source files
------------

// File: rtl/plab5_mcore_mem_req_tracker_pkg.sv
// Shared definitions for the memory request tracker: domain labels and
// message/entry width helpers matching the vc-mem message layout.
package plab5_mcore_mem_req_tracker_pkg;

  localparam int unsigned TYPE_W = 3;

  typedef enum logic {
    DOMAIN_LOW  = 1'b0,
    DOMAIN_HIGH = 1'b1
  } domain_e;

  function automatic int unsigned len_nbits(input int unsigned md);
    return $clog2(md / 8);
  endfunction

  // Request layout, MSB first: {type, opaque, addr, len, data}
  function automatic int unsigned req_msg_nbits(input int unsigned o, input int unsigned a,
                                                input int unsigned md);
    return TYPE_W + o + a + len_nbits(md) + md;
  endfunction

  // Response layout, MSB first: {type, opaque, len, data}
  function automatic int unsigned resp_msg_nbits(input int unsigned o, input int unsigned md);
    return TYPE_W + o + len_nbits(md) + md;
  endfunction

  // Outstanding entry layout, MSB first: {domain, opaque, type}
  function automatic int unsigned entry_nbits(input int unsigned o);
    return 1 + o + TYPE_W;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_req_tracker_if.sv
// Handshake bundle around the tracker: translator-side request/response and
// memory-side request/response channels.
interface plab5_mcore_mem_req_tracker_if
  import plab5_mcore_mem_req_tracker_pkg::*;
#(
  parameter int unsigned o  = 8,
  parameter int unsigned a  = 32,
  parameter int unsigned md = 128
);
  localparam int unsigned REQ_W  = req_msg_nbits(o, a, md);
  localparam int unsigned RESP_W = resp_msg_nbits(o, md);

  logic              req_domain;
  logic [REQ_W-1:0]  req_msg;
  logic              req_val;
  logic              req_rdy;

  logic [REQ_W-1:0]  memreq_msg;
  logic              memreq_domain;
  logic              memreq_val;
  logic              memreq_rdy;

  logic [RESP_W-1:0] memresp_msg;
  logic              memresp_val;
  logic              memresp_rdy;

  logic [RESP_W-1:0] resp_msg;
  logic              resp_domain;
  logic              resp_val;
  logic              resp_rdy;

  modport master (
    output req_domain, req_msg, req_val, memreq_rdy, memresp_msg, memresp_val, resp_rdy,
    input  req_rdy, memreq_msg, memreq_domain, memreq_val, memresp_rdy, resp_msg,
           resp_domain, resp_val
  );

  modport slave (
    input  req_domain, req_msg, req_val, memreq_rdy, memresp_msg, memresp_val, resp_rdy,
    output req_rdy, memreq_msg, memreq_domain, memreq_val, memresp_rdy, resp_msg,
           resp_domain, resp_val
  );

endinterface

// File: rtl/plab5_mcore_tracker_fifo.sv
// In-order circular buffer of outstanding request records. The caller gates
// push/pop against full/empty; this block only keeps pointers and count.
module plab5_mcore_tracker_fifo #(
  parameter int unsigned width       = 12,
  parameter int unsigned num_entries = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [width-1:0]              wdata_i,
  output logic [width-1:0]              rdata_o,
  output logic [$clog2(num_entries):0]  count_o,
  output logic                          full_o,
  output logic                          empty_o
);
  localparam int unsigned PW = $clog2(num_entries);

  logic [width-1:0] mem_q [num_entries];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW:0]      count_q, count_d;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + 1'b1;
    if (pop_i)  head_d = head_q + 1'b1;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count alone says which slots are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PW+1)'(num_entries));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/plab5_mcore_mem_req_tracker.sv
// Forwards requests to memory with zero latency, remembers each accepted
// request's domain, and labels every memory response with the oldest record.
module plab5_mcore_mem_req_tracker
  import plab5_mcore_mem_req_tracker_pkg::*;
#(
  parameter int unsigned o           = 8,
  parameter int unsigned a           = 32,
  parameter int unsigned md          = 128,
  parameter int unsigned num_entries = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  plab5_mcore_mem_req_tracker_if.slave  bus,
  output logic [$clog2(num_entries):0]  count,
  output logic                          err
);
  localparam int unsigned REQ_W  = req_msg_nbits(o, a, md);
  localparam int unsigned RESP_W = resp_msg_nbits(o, md);
  localparam int unsigned ENT_W  = entry_nbits(o);

  logic              full, empty, push, pop, match;
  logic [ENT_W-1:0]  head_ent;
  logic [TYPE_W-1:0] req_type, resp_type, head_type;
  logic [o-1:0]      req_opaque, resp_opaque, head_opaque;
  domain_e           head_domain;
  logic              err_q, err_d;

  assign req_type    = bus.req_msg[REQ_W-1 -: TYPE_W];
  assign req_opaque  = bus.req_msg[REQ_W-TYPE_W-1 -: o];
  assign resp_type   = bus.memresp_msg[RESP_W-1 -: TYPE_W];
  assign resp_opaque = bus.memresp_msg[RESP_W-TYPE_W-1 -: o];

  assign head_domain = domain_e'(head_ent[ENT_W-1]);
  assign head_opaque = head_ent[TYPE_W +: o];
  assign head_type   = head_ent[TYPE_W-1:0];

  // Request path: a full tracker refuses new work even if a pop lands this cycle.
  assign bus.memreq_msg    = bus.req_msg;
  assign bus.memreq_domain = bus.req_domain;
  assign bus.memreq_val    = reset & bus.req_val & ~full;
  assign bus.req_rdy       = reset & bus.memreq_rdy & ~full;
  assign push              = bus.req_val & bus.req_rdy;

  // Response path: unsolicited responses are sunk so memory never stalls on them.
  assign match           = (resp_opaque == head_opaque) && (resp_type == head_type);
  assign bus.resp_msg    = bus.memresp_msg;
  assign bus.resp_val    = reset & ~empty & bus.memresp_val;
  assign bus.memresp_rdy = reset & (empty | bus.resp_rdy);
  assign pop             = reset & ~empty & bus.memresp_val & bus.resp_rdy;

  // Anything not provably tied to the head record is labelled high, never low.
  assign bus.resp_domain = (reset && !empty && match) ? head_domain : DOMAIN_HIGH;

  assign err_d = err_q | (pop & ~match) | (reset & empty & bus.memresp_val);

  always_ff @(posedge clk) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;

  plab5_mcore_tracker_fifo #(
    .width       (ENT_W),
    .num_entries (num_entries)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.req_domain, req_opaque, req_type}),
    .rdata_o (head_ent),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule
